// File: rtl/cpu_pkg.sv
// Shared RV32I encodings, control enums and the immediate/ALU-select helpers
// used by the single-cycle core.
package cpu_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  typedef enum logic [2:0] {
    WB_ALU, WB_MEM, WB_PC4, WB_IMM, WB_PCIMM
  } wb_sel_e;

  typedef enum logic [2:0] {
    IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
  } imm_type_e;

  typedef enum logic {
    ST_RUN, ST_HALT
  } core_state_e;

  function automatic logic [31:0] gen_imm(input logic [31:0] instr, input imm_type_e t);
    logic [31:0] imm;
    case (t)
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = {{20{instr[31]}}, instr[31:20]};
    endcase
    return imm;
  endfunction

  // SUB only exists in the register form; SRAI shares instr[30] with SRA.
  function automatic alu_op_e decode_alu(input logic [2:0] f3, input logic f7_5,
                                         input logic is_reg);
    alu_op_e op;
    case (f3)
      F3_ADD_SUB: op = (is_reg && f7_5) ? ALU_SUB : ALU_ADD;
      F3_SLL:     op = ALU_SLL;
      F3_SLT:     op = ALU_SLT;
      F3_SLTU:    op = ALU_SLTU;
      F3_XOR:     op = ALU_XOR;
      F3_SRL_SRA: op = f7_5 ? ALU_SRA : ALU_SRL;
      F3_OR:      op = ALU_OR;
      default:    op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/cpu_if.sv
// Harvard memory bus between the core and its external ROM/RAM.
interface cpu_if;
  logic [31:0] Instruction;
  logic [31:0] data_DMEM;
  logic [9:0]  address_IMEM;
  logic [9:0]  address_DMEM;
  logic [31:0] write_data_DMEM;
  logic        MemWrite;
  logic        MemRead;

  modport master (
    input  Instruction, data_DMEM,
    output address_IMEM, address_DMEM, write_data_DMEM, MemWrite, MemRead
  );

  modport slave (
    output Instruction, data_DMEM,
    input  address_IMEM, address_DMEM, write_data_DMEM, MemWrite, MemRead
  );
endinterface

// File: rtl/cpu_regfile.sv
// 32 x 32 register file: two combinational reads, one write, x0 hardwired to zero.
module cpu_regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);

  logic [31:0] rf_rd [32];

  for (genvar gi = 0; gi < 32; gi++) begin : g_reg
    if (gi == 0) begin : g_zero
      assign rf_rd[gi] = '0;
    end else begin : g_flop
      logic [31:0] reg_q, reg_d;

      always_comb begin
        reg_d = reg_q;
        if (we && (waddr == 5'(gi))) reg_d = wdata;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) reg_q <= '0;
        else        reg_q <= reg_d;
      end

      assign rf_rd[gi] = reg_q;
    end
  end

  assign rdata1 = rf_rd[raddr1];
  assign rdata2 = rf_rd[raddr2];

endmodule

// File: rtl/cpu_core.sv
// Single-cycle RV32I core: fetch, decode, execute and retire one instruction per
// clock against combinational ROM/RAM; an all-zero instruction halts until reset.
module cpu_core
  import cpu_pkg::*;
(
  input  logic  CLK,
  input  logic  RSTn,
  cpu_if.master bus
);

  core_state_e state_q, state_d;
  logic [31:0] pc_q, pc_d;

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic        halt_instr;

  assign instr      = bus.Instruction;
  assign opcode     = instr[6:0];
  assign rd         = instr[11:7];
  assign funct3     = instr[14:12];
  assign rs1        = instr[19:15];
  assign rs2        = instr[24:20];
  assign funct7_5   = instr[30];
  assign halt_instr = (instr == 32'h0000_0000);

  alu_op_e   alu_op;
  wb_sel_e   wb_sel;
  imm_type_e imm_type;
  logic      alu_src_imm, reg_write, is_load, is_store, is_branch, is_jal, is_jalr;

  // Narrow loads/stores fall into the word forms; unknown opcodes stay NOPs.
  always_comb begin
    alu_op      = ALU_ADD;
    wb_sel      = WB_ALU;
    imm_type    = IMM_I;
    alu_src_imm = 1'b0;
    reg_write   = 1'b0;
    is_load     = 1'b0;
    is_store    = 1'b0;
    is_branch   = 1'b0;
    is_jal      = 1'b0;
    is_jalr     = 1'b0;
    case (opcode)
      OPC_LUI: begin
        imm_type  = IMM_U;
        wb_sel    = WB_IMM;
        reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        imm_type  = IMM_U;
        wb_sel    = WB_PCIMM;
        reg_write = 1'b1;
      end
      OPC_JAL: begin
        imm_type  = IMM_J;
        wb_sel    = WB_PC4;
        reg_write = 1'b1;
        is_jal    = 1'b1;
      end
      OPC_JALR: begin
        alu_src_imm = 1'b1;
        wb_sel      = WB_PC4;
        reg_write   = 1'b1;
        is_jalr     = 1'b1;
      end
      OPC_BRANCH: begin
        imm_type  = IMM_B;
        is_branch = 1'b1;
      end
      OPC_LOAD: begin
        alu_src_imm = 1'b1;
        wb_sel      = WB_MEM;
        reg_write   = 1'b1;
        is_load     = 1'b1;
      end
      OPC_STORE: begin
        imm_type    = IMM_S;
        alu_src_imm = 1'b1;
        is_store    = 1'b1;
      end
      OPC_OP_IMM: begin
        alu_src_imm = 1'b1;
        reg_write   = 1'b1;
        alu_op      = decode_alu(funct3, funct7_5, 1'b0);
      end
      OPC_OP: begin
        reg_write = 1'b1;
        alu_op    = decode_alu(funct3, funct7_5, 1'b1);
      end
      default: ;
    endcase
  end

  logic [31:0] imm;
  assign imm = gen_imm(instr, imm_type);

  logic        rf_we;
  logic [31:0] rf_wdata, rs1_val, rs2_val;

  cpu_regfile u_regfile (
    .clk    (CLK),
    .rst_n  (RSTn),
    .we     (rf_we),
    .waddr  (rd),
    .wdata  (rf_wdata),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rs1_val),
    .rdata2 (rs2_val)
  );

  logic [31:0] alu_b, alu_result;
  logic [4:0]  shamt;

  assign alu_b = alu_src_imm ? imm : rs2_val;
  assign shamt = alu_b[4:0];

  always_comb begin
    alu_result = rs1_val + alu_b;
    case (alu_op)
      ALU_SUB:  alu_result = rs1_val - alu_b;
      ALU_SLL:  alu_result = rs1_val << shamt;
      ALU_SLT:  alu_result = {31'b0, $signed(rs1_val) < $signed(alu_b)};
      ALU_SLTU: alu_result = {31'b0, rs1_val < alu_b};
      ALU_XOR:  alu_result = rs1_val ^ alu_b;
      ALU_SRL:  alu_result = rs1_val >> shamt;
      ALU_SRA:  alu_result = $unsigned($signed(rs1_val) >>> shamt);
      ALU_OR:   alu_result = rs1_val | alu_b;
      ALU_AND:  alu_result = rs1_val & alu_b;
      default:  ;
    endcase
  end

  logic br_eq, br_lt, br_ltu, br_taken;
  assign br_eq  = (rs1_val == rs2_val);
  assign br_lt  = ($signed(rs1_val) < $signed(rs2_val));
  assign br_ltu = (rs1_val < rs2_val);

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      F3_BEQ:  br_taken = br_eq;
      F3_BNE:  br_taken = !br_eq;
      F3_BLT:  br_taken = br_lt;
      F3_BGE:  br_taken = !br_lt;
      F3_BLTU: br_taken = br_ltu;
      F3_BGEU: br_taken = !br_ltu;
      default: ;
    endcase
  end

  logic [31:0] pc_plus4, pc_plus_imm, next_pc;
  assign pc_plus4    = pc_q + 32'd4;
  assign pc_plus_imm = pc_q + imm;

  always_comb begin
    next_pc = pc_plus4;
    if (is_jal || (is_branch && br_taken)) next_pc = pc_plus_imm;
    else if (is_jalr)                      next_pc = {alu_result[31:1], 1'b0};
  end

  always_comb begin
    rf_wdata = alu_result;
    case (wb_sel)
      WB_MEM:   rf_wdata = bus.data_DMEM;
      WB_PC4:   rf_wdata = pc_plus4;
      WB_IMM:   rf_wdata = imm;
      WB_PCIMM: rf_wdata = pc_plus_imm;
      default:  ;
    endcase
  end

  // The zero word is latched as a sticky halt so nothing but reset restarts fetch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    rf_we   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (halt_instr) begin
          state_d = ST_HALT;
        end else begin
          pc_d  = next_pc;
          rf_we = reg_write;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= ST_RUN;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Gating with RSTn keeps RAM strobes low for the whole reset, even mid-instruction.
  logic exec_en;
  assign exec_en = RSTn && (state_q == ST_RUN) && !halt_instr;

  assign bus.address_IMEM    = pc_q[11:2];
  assign bus.address_DMEM    = alu_result[11:2];
  assign bus.write_data_DMEM = rs2_val;
  assign bus.MemWrite        = exec_en && is_store;
  assign bus.MemRead         = exec_en && is_load;

endmodule

// File: tb/tb_cpu_core.sv
// Directed programs for cpu_core: Fibonacci, ALU/memory, control flow and reset mid-run,
// with results stored to RAM and compared against hand-computed values.
`timescale 1ns/1ps
module tb_cpu_core;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cpu_if bus ();

  cpu_core dut (
    .CLK  (clk),
    .RSTn (rst_n),
    .bus  (bus)
  );

  logic [31:0] rom [1024];
  logic [31:0] ram [1024];
  logic        ram_clear = 1'b0;
  int          n_checks = 0;
  int          n_pass = 0;

  localparam logic [6:0] OPI = 7'h13;
  localparam logic [6:0] OPR = 7'h33;

  assign bus.Instruction = rom[bus.address_IMEM];
  assign bus.data_DMEM   = ram[bus.address_DMEM];

  always @(posedge clk) begin
    if (ram_clear) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 32'hDEAD_BEEF;
    end else if (bus.MemWrite) begin
      ram[bus.address_DMEM] <= bus.write_data_DMEM;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end else begin
      n_pass++;
      $display("ok   %s: %08h", tag, got);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OPR};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 1024; i++) rom[i] = 32'h0;
  endtask

  task automatic hold_reset();
    rst_n     = 1'b0;
    ram_clear = 1'b1;
    repeat (2) @(negedge clk);
    ram_clear = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_pc(input logic [9:0] target, input int budget);
    int n = 0;
    while (bus.address_IMEM != target && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_halt(input int budget);
    int n = 0;
    while (bus.Instruction != 32'h0 && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  logic [31:0] fib_exp [10] = '{32'd0, 32'd1, 32'd1, 32'd2, 32'd3,
                                32'd5, 32'd8, 32'd13, 32'd21, 32'd34};

  initial begin
    // Fibonacci: F(0..9) stored to words 0..9, loop closed by BNE.
    clear_rom();
    rom[0] = enc_i(12'd0, 5'd0, 3'd0, 5'd1, OPI);
    rom[1] = enc_i(12'd1, 5'd0, 3'd0, 5'd2, OPI);
    rom[2] = enc_i(12'd0, 5'd0, 3'd0, 5'd3, OPI);
    rom[3] = enc_i(12'd40, 5'd0, 3'd0, 5'd4, OPI);
    rom[4] = enc_s(12'd0, 5'd1, 5'd3);
    rom[5] = enc_r(7'd0, 5'd2, 5'd1, 3'd0, 5'd5);
    rom[6] = enc_i(12'd0, 5'd2, 3'd0, 5'd1, OPI);
    rom[7] = enc_i(12'd0, 5'd5, 3'd0, 5'd2, OPI);
    rom[8] = enc_i(12'd4, 5'd3, 3'd0, 5'd3, OPI);
    rom[9] = enc_b(13'h1FEC, 5'd4, 5'd3, 3'b001);
    hold_reset();
    check_eq("rst_imem", 32'(bus.address_IMEM), 32'd0);
    check_eq("rst_memwrite", 32'(bus.MemWrite), 32'd0);
    check_eq("rst_memread", 32'(bus.MemRead), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("first_retire_imem", 32'(bus.address_IMEM), 32'd1);
    wait_halt(300);
    check_eq("fib_halt_imem", 32'(bus.address_IMEM), 32'd10);
    repeat (3) @(negedge clk);
    check_eq("fib_pc_frozen", 32'(bus.address_IMEM), 32'd10);
    check_eq("fib_halt_memwrite", 32'(bus.MemWrite), 32'd0);
    for (int i = 0; i < 10; i++) check_eq($sformatf("fib_ram%0d", i), ram[i], fib_exp[i]);

    // ALU, x0, LUI/AUIPC and SW/LW round trip; results stored to words 16..24.
    clear_rom();
    rom[0]  = enc_i(12'hFFF, 5'd0, 3'd0, 5'd1, OPI);
    rom[1]  = enc_i(12'd28, 5'd1, 3'b101, 5'd2, OPI);
    rom[2]  = enc_i(12'h41C, 5'd1, 3'b101, 5'd3, OPI);
    rom[3]  = enc_r(7'd0, 5'd1, 5'd0, 3'b011, 5'd4);
    rom[4]  = enc_r(7'h20, 5'd1, 5'd0, 3'b000, 5'd5);
    rom[5]  = enc_i(12'd5, 5'd0, 3'd0, 5'd0, OPI);
    rom[6]  = {20'h12345, 5'd7, 7'h37};
    rom[7]  = enc_r(7'd0, 5'd0, 5'd1, 3'b010, 5'd9);
    rom[8]  = {20'h00001, 5'd8, 7'h17};
    rom[9]  = enc_s(12'd8, 5'd1, 5'd0);
    rom[10] = enc_i(12'd8, 5'd0, 3'b010, 5'd6, 7'h03);
    rom[11] = enc_s(12'd64, 5'd2, 5'd0);
    rom[12] = enc_s(12'd68, 5'd3, 5'd0);
    rom[13] = enc_s(12'd72, 5'd4, 5'd0);
    rom[14] = enc_s(12'd76, 5'd5, 5'd0);
    rom[15] = enc_s(12'd80, 5'd0, 5'd0);
    rom[16] = enc_s(12'd84, 5'd7, 5'd0);
    rom[17] = enc_s(12'd88, 5'd8, 5'd0);
    rom[18] = enc_s(12'd92, 5'd9, 5'd0);
    rom[19] = enc_s(12'd96, 5'd6, 5'd0);
    hold_reset();
    rst_n = 1'b1;
    wait_pc(10'd9, 20);
    check_eq("sw_cycle_imem", 32'(bus.address_IMEM), 32'd9);
    check_eq("sw_addr_dmem", 32'(bus.address_DMEM), 32'd2);
    check_eq("sw_memwrite", 32'(bus.MemWrite), 32'd1);
    check_eq("sw_wdata", bus.write_data_DMEM, 32'hFFFF_FFFF);
    @(negedge clk);
    check_eq("lw_memread", 32'(bus.MemRead), 32'd1);
    check_eq("lw_memwrite", 32'(bus.MemWrite), 32'd0);
    wait_halt(50);
    check_eq("alu_halt_imem", 32'(bus.address_IMEM), 32'd20);
    check_eq("srli_x2", ram[16], 32'h0000_000F);
    check_eq("srai_x3", ram[17], 32'hFFFF_FFFF);
    check_eq("sltu_x4", ram[18], 32'd1);
    check_eq("sub_x5", ram[19], 32'd1);
    check_eq("x0_stays_zero", ram[20], 32'd0);
    check_eq("lui_x7", ram[21], 32'h1234_5000);
    check_eq("auipc_x8", ram[22], 32'h0000_1020);
    check_eq("slt_x9", ram[23], 32'd1);
    check_eq("lw_x6", ram[24], 32'hFFFF_FFFF);

    // Control flow: JAL, JALR back, BLT taken, BLTU not taken.
    clear_rom();
    rom[0]  = enc_i(12'hFFF, 5'd0, 3'd0, 5'd2, OPI);
    rom[1]  = enc_i(12'd1, 5'd0, 3'd0, 5'd3, OPI);
    rom[2]  = enc_i(12'd0, 5'd0, 3'd0, 5'd10, OPI);
    rom[3]  = enc_i(12'd0, 5'd0, 3'd0, 5'd11, OPI);
    rom[4]  = enc_j(21'd8, 5'd1);
    rom[5]  = enc_j(21'd8, 5'd0);
    rom[6]  = enc_i(12'd0, 5'd1, 3'd0, 5'd0, 7'h67);
    rom[7]  = enc_b(13'd8, 5'd3, 5'd2, 3'b100);
    rom[8]  = enc_i(12'd99, 5'd0, 3'd0, 5'd10, OPI);
    rom[9]  = enc_b(13'd8, 5'd3, 5'd2, 3'b110);
    rom[10] = enc_i(12'd77, 5'd0, 3'd0, 5'd11, OPI);
    rom[11] = enc_s(12'd0, 5'd1, 5'd0);
    rom[12] = enc_s(12'd4, 5'd10, 5'd0);
    rom[13] = enc_s(12'd8, 5'd11, 5'd0);
    hold_reset();
    rst_n = 1'b1;
    wait_pc(10'd4, 20);
    check_eq("jal_at_0x10", 32'(bus.address_IMEM), 32'd4);
    @(negedge clk);
    check_eq("jal_next_imem", 32'(bus.address_IMEM), 32'd6);
    @(negedge clk);
    check_eq("jalr_next_imem", 32'(bus.address_IMEM), 32'd5);
    @(negedge clk);
    check_eq("jal_fwd_imem", 32'(bus.address_IMEM), 32'd7);
    @(negedge clk);
    check_eq("blt_taken_imem", 32'(bus.address_IMEM), 32'd9);
    @(negedge clk);
    check_eq("bltu_not_taken_imem", 32'(bus.address_IMEM), 32'd10);
    wait_halt(30);
    check_eq("ctl_halt_imem", 32'(bus.address_IMEM), 32'd14);
    check_eq("jal_link_x1", ram[0], 32'h0000_0014);
    check_eq("blt_skip_x10", ram[1], 32'd0);
    check_eq("bltu_fall_x11", ram[2], 32'd77);

    // Reset asserted while a SW is decoded: no write, fetch restarts from 0.
    clear_rom();
    rom[0] = enc_i(12'd123, 5'd0, 3'd0, 5'd1, OPI);
    rom[1] = enc_s(12'd0, 5'd1, 5'd0);
    hold_reset();
    rst_n = 1'b1;
    wait_pc(10'd1, 10);
    check_eq("rr_sw_memwrite", 32'(bus.MemWrite), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("rr_imem_now", 32'(bus.address_IMEM), 32'd0);
    check_eq("rr_memwrite_forced", 32'(bus.MemWrite), 32'd0);
    @(negedge clk);
    check_eq("rr_no_ram_write", ram[0], 32'hDEAD_BEEF);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rr_restart_imem", 32'(bus.address_IMEM), 32'd1);
    wait_halt(20);
    check_eq("rr_halt_imem", 32'(bus.address_IMEM), 32'd2);
    check_eq("rr_ram_after", ram[0], 32'd123);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed",
             n_pass, n_checks);
    $fatal(1, "timeout");
  end

endmodule
